bicubic_ctrl: RTL and testbench
===============================

BICUBIC_CTRL -- requirements
Module: bicubic_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_W, default 100, giving the source image row pitch in pixels.
REQ-002 The block SHALL have parameter ROM_AW, default 14, giving the ROM address width.
REQ-003 The block SHALL have parameter SRAM_AW, default 12, giving the result SRAM address width.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have ports START (input, 1 bit) and BUSY (output, 1 bit): START is the job request; BUSY is high from job start until DONE.
REQ-007 The block SHALL have ports H0 and V0 (inputs, 7 bits each) and SW and SH (inputs, 5 bits each): ROI origin and size in the source image.
REQ-008 The block SHALL have ports TW and TH (inputs, 6 bits each): target width and height.
REQ-009 The block SHALL have ports ROM_REQ (output, 1 bit) and ROM_A (output, ROM_AW bits): ROM read strobe and address.
REQ-010 The block SHALL have ports PIX_VALID and WIN_LAST (outputs, 1 bit each): ROM data valid for the datapath, and the 16th tap of a window.
REQ-011 The block SHALL have ports FX_NUM, FY_NUM, FX_DEN and FY_DEN (outputs, 6 bits each): fractional position numerators and denominators.
REQ-012 The block SHALL have port DP_DONE (input, 1 bit): the datapath result is ready.
REQ-013 The block SHALL have ports SRAM_WEN (output, 1 bit), SRAM_A (output, SRAM_AW bits), DONE (output, 1 bit) and WIN_REUSE (output, 1 bit).

Function
REQ-014 FSM SHALL have states IDLE, SETUP, FETCH, WAIT, WRITE, NEXT and FINISH.
REQ-015 In IDLE or FINISH, START=1 SHALL latch H0/V0/SW/SH/TW/TH, clear DONE, set BUSY and go to SETUP; START while BUSY is ignored.
REQ-016 Targets SHALL be visited in raster order (ty outer, tx inner), with SRAM_A = ty*TW+tx held by an incremental counter.
REQ-017 Per axis: sx = floor(tx*(SW-1)/(TW-1)), FX_NUM = remainder, FX_DEN = TW-1, computed by an accumulator (add SW-1, subtract TW-1 on overflow), with no divider.
REQ-018 If TW==1 then sx=0, FX_NUM=0, FX_DEN=1; the same rules apply to the y axis with SH/TH.
REQ-019 FETCH SHALL issue 16 consecutive ROM_REQ cycles, row-major, over rows sy-1..sy+2 and columns sx-1..sx+2, each clamped to [0,SW-1]/[0,SH-1].
REQ-020 The fetch address SHALL be ROM_A = (V0+row)*IMG_W + H0+col.
REQ-021 PIX_VALID SHALL follow each ROM_REQ by exactly 1 cycle; WIN_LAST SHALL accompany the 16th PIX_VALID.
REQ-022 FX/FY outputs SHALL be stable from the first ROM_REQ of a window through its SRAM write.
REQ-023 WAIT SHALL hold until DP_DONE=1, including when DP_DONE arrives together with WIN_LAST; WRITE SHALL pulse SRAM_WEN for 1 cycle.
REQ-024 After the last write (tx=TW-1, ty=TH-1), FINISH SHALL set DONE=1 and BUSY=0, and DONE SHALL hold until the next START.

Reset
REQ-025 On RST, all outputs SHALL be 0, the FSM SHALL enter IDLE and counters SHALL clear, asynchronously, including mid-job; a job does not resume after reset.

Configuration
REQ-026 With BICUBIC_REUSE_EN defined, a non-first pixel of a row with (sx,sy) equal to the previous pixel SHALL skip FETCH, pulse WIN_REUSE 1 cycle and enter WAIT.
REQ-027 Without BICUBIC_REUSE_EN, every pixel SHALL fetch and WIN_REUSE SHALL be tied 0.

Structure
REQ-028 Package bicubic_pkg SHALL hold IMG_W, the address widths and the FSM state enum.
REQ-029 Sub-module bicubic_axis_step (accumulator, integer index and remainder) SHALL be instantiated twice, once for x and once for y.

Verification
REQ-030 RST high for 2 cycles -> DONE, BUSY, ROM_REQ and SRAM_WEN are all 0, and the FSM is in IDLE.
REQ-031 H0=V0=0, SW=SH=TW=TH=4, DP_DONE 3 cycles after WIN_LAST -> first window ROM_A is 0,0,1,2,0,0,1,2,100,100,101,102,200,200,201,202; SRAM_A runs 0..15; DONE is 1 after the 16th write.
REQ-032 SW=5, TW=9 -> sx runs 0,0,1,1,2,2,3,3,4, FX_NUM alternates 0/4 and FX_DEN=8.
REQ-033 H0=V0=90, SW=SH=TW=TH=10 -> last window's final row ROM_A is 9998,9999,9999,9999.
REQ-034 RST asserted in the 5th FETCH cycle -> outputs are 0 immediately; after release the block idles until START, then completes normally.
REQ-035 SW=SH=5, TW=TH=9 -> 720 ROM_REQ with BICUBIC_REUSE_EN and 1296 without, with identical SRAM_A sequences in both cases.

Source files
------------

// File: rtl/bicubic_pkg.sv
// bicubic_pkg: default widths, source row pitch and controller state encoding.
// States: IDLE wait START | SETUP clear counters | FETCH 16 taps | WAIT datapath | WRITE SRAM | NEXT step axes | FINISH done
package bicubic_pkg;
    localparam int IMG_W   = 100;
    localparam int ROM_AW  = 14;
    localparam int SRAM_AW = 12;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        FETCH  = 3'd2,
        WAIT   = 3'd3,
        WRITE  = 3'd4,
        NEXT   = 3'd5,
        FINISH = 3'd6
    } state_e;
endpackage

// File: rtl/bicubic_axis_step.sv
// bicubic_axis_step: divider-free floor(t*inc/den) tracker; one step per target index,
// then repeated subtraction until the remainder drops below den (ready).
module bicubic_axis_step (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       clr,
    input  logic       step,
    input  logic [4:0] inc,
    input  logic [5:0] den,
    output logic [4:0] idx,
    output logic [5:0] rem,
    output logic       ready
);
    logic [6:0] acc_q, acc_d;
    logic [4:0] idx_q, idx_d;

    assign ready = (den == 6'd0) || (acc_q < {1'b0, den});
    assign idx   = idx_q;
    assign rem   = acc_q[5:0];

    always_comb begin
        acc_d = acc_q;
        idx_d = idx_q;
        if (clr) begin
            acc_d = 7'd0;
            idx_d = 5'd0;
        end else if (step) begin
            acc_d = acc_q + {2'b00, inc};
        end else if (!ready) begin
            acc_d = acc_q - {1'b0, den};
            idx_d = idx_q + 5'd1;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            acc_q <= 7'd0;
            idx_q <= 5'd0;
        end else begin
            acc_q <= acc_d;
            idx_q <= idx_d;
        end
    end
endmodule

// File: rtl/bicubic_ctrl.sv
// bicubic_ctrl: walks target pixels in raster order, fetches each 4x4 source window
// from ROM and writes one SRAM result per pixel. Window reuse under BICUBIC_REUSE_EN.
module bicubic_ctrl #(
    parameter int IMG_W   = bicubic_pkg::IMG_W,
    parameter int ROM_AW  = bicubic_pkg::ROM_AW,
    parameter int SRAM_AW = bicubic_pkg::SRAM_AW
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    output logic               BUSY,
    input  logic [6:0]         H0,
    input  logic [6:0]         V0,
    input  logic [4:0]         SW,
    input  logic [4:0]         SH,
    input  logic [5:0]         TW,
    input  logic [5:0]         TH,
    output logic               ROM_REQ,
    output logic [ROM_AW-1:0]  ROM_A,
    output logic               PIX_VALID,
    output logic               WIN_LAST,
    output logic [5:0]         FX_NUM,
    output logic [5:0]         FY_NUM,
    output logic [5:0]         FX_DEN,
    output logic [5:0]         FY_DEN,
    input  logic               DP_DONE,
    output logic               SRAM_WEN,
    output logic [SRAM_AW-1:0] SRAM_A,
    output logic               DONE,
    output logic               WIN_REUSE
);
    import bicubic_pkg::*;

    state_e             state_q, state_d;
    logic [6:0]         h0_q, h0_d, v0_q, v0_d;
    logic [4:0]         sw_q, sw_d, sh_q, sh_d;
    logic [5:0]         tw_q, tw_d, th_q, th_d;
    logic [5:0]         fx_den_q, fx_den_d, fy_den_q, fy_den_d;
    logic [5:0]         tx_q, tx_d, ty_q, ty_d;
    logic [3:0]         tap_q, tap_d;
    logic [SRAM_AW-1:0] sram_a_q, sram_a_d;
    logic               pix_valid_q, pix_valid_d, win_last_q, win_last_d;
    logic               x_clr, x_step, y_clr, y_step, x_rdy, y_rdy;
    logic [4:0]         sx, sy, row_c, col_c;
    logic [5:0]         fx_rem, fy_rem;
    logic [6:0]         row_i, col_i;
    logic               last_px, reuse_hit;

    bicubic_axis_step u_x (.clk_sys(CLK), .rst(RST), .clr(x_clr), .step(x_step),
        .inc(sw_q - 5'd1), .den(fx_den_q), .idx(sx), .rem(fx_rem), .ready(x_rdy));
    bicubic_axis_step u_y (.clk_sys(CLK), .rst(RST), .clr(y_clr), .step(y_step),
        .inc(sh_q - 5'd1), .den(fy_den_q), .idx(sy), .rem(fy_rem), .ready(y_rdy));

    assign last_px = (tx_q == tw_q - 6'd1) && (ty_q == th_q - 6'd1);

    // Tap offsets are -1..+2 around (sx,sy); row_i/col_i carry that +1 bias so they stay unsigned.
    always_comb begin
        row_i = {2'b00, sy} + {5'b00000, tap_q[3:2]};
        col_i = {2'b00, sx} + {5'b00000, tap_q[1:0]};
        if (row_i == 7'd0)               row_c = 5'd0;
        else if (row_i > {2'b00, sh_q})  row_c = sh_q - 5'd1;
        else                             row_c = 5'(row_i - 7'd1);
        if (col_i == 7'd0)               col_c = 5'd0;
        else if (col_i > {2'b00, sw_q})  col_c = sw_q - 5'd1;
        else                             col_c = 5'(col_i - 7'd1);
    end

    always_comb begin
        state_d     = state_q;
        h0_d        = h0_q;
        v0_d        = v0_q;
        sw_d        = sw_q;
        sh_d        = sh_q;
        tw_d        = tw_q;
        th_d        = th_q;
        fx_den_d    = fx_den_q;
        fy_den_d    = fy_den_q;
        tx_d        = tx_q;
        ty_d        = ty_q;
        tap_d       = tap_q;
        sram_a_d    = sram_a_q;
        x_clr       = 1'b0;
        x_step      = 1'b0;
        y_clr       = 1'b0;
        y_step      = 1'b0;
        pix_valid_d = (state_q == FETCH);
        win_last_d  = (state_q == FETCH) && (tap_q == 4'd15);
        case (state_q)
            IDLE, FINISH: if (START) begin
                h0_d     = H0;
                v0_d     = V0;
                sw_d     = SW;
                sh_d     = SH;
                tw_d     = TW;
                th_d     = TH;
                fx_den_d = (TW > 6'd1) ? TW - 6'd1 : 6'd1;
                fy_den_d = (TH > 6'd1) ? TH - 6'd1 : 6'd1;
                state_d  = SETUP;
            end
            SETUP: begin
                x_clr    = 1'b1;
                y_clr    = 1'b1;
                tx_d     = 6'd0;
                ty_d     = 6'd0;
                tap_d    = 4'd0;
                sram_a_d = '0;
                state_d  = FETCH;
            end
            FETCH: begin
                tap_d = tap_q + 4'd1;
                if (tap_q == 4'd15) state_d = WAIT;
            end
            WAIT: if (DP_DONE) state_d = WRITE;
            WRITE: begin
                if (last_px) begin
                    state_d = FINISH;
                end else begin
                    sram_a_d = sram_a_q + SRAM_AW'(1);
                    if (tx_q == tw_q - 6'd1) begin
                        tx_d   = 6'd0;
                        x_clr  = 1'b1;
                        ty_d   = ty_q + 6'd1;
                        y_step = 1'b1;
                    end else begin
                        tx_d   = tx_q + 6'd1;
                        x_step = 1'b1;
                    end
                    state_d = NEXT;
                end
            end
            NEXT: if (x_rdy && y_rdy) state_d = reuse_hit ? WAIT : FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            h0_q        <= 7'd0;
            v0_q        <= 7'd0;
            sw_q        <= 5'd0;
            sh_q        <= 5'd0;
            tw_q        <= 6'd0;
            th_q        <= 6'd0;
            fx_den_q    <= 6'd0;
            fy_den_q    <= 6'd0;
            tx_q        <= 6'd0;
            ty_q        <= 6'd0;
            tap_q       <= 4'd0;
            sram_a_q    <= '0;
            pix_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            h0_q        <= h0_d;
            v0_q        <= v0_d;
            sw_q        <= sw_d;
            sh_q        <= sh_d;
            tw_q        <= tw_d;
            th_q        <= th_d;
            fx_den_q    <= fx_den_d;
            fy_den_q    <= fy_den_d;
            tx_q        <= tx_d;
            ty_q        <= ty_d;
            tap_q       <= tap_d;
            sram_a_q    <= sram_a_d;
            pix_valid_q <= pix_valid_d;
            win_last_q  <= win_last_d;
        end
    end

`ifdef BICUBIC_REUSE_EN
    logic [4:0] sx_prev_q, sx_prev_d, sy_prev_q, sy_prev_d;
    logic       win_reuse_q, win_reuse_d;

    assign reuse_hit   = (tx_q != 6'd0) && (sx == sx_prev_q) && (sy == sy_prev_q);
    assign sx_prev_d   = (state_q == WRITE) ? sx : sx_prev_q;
    assign sy_prev_d   = (state_q == WRITE) ? sy : sy_prev_q;
    assign win_reuse_d = (state_q == NEXT) && x_rdy && y_rdy && reuse_hit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sx_prev_q   <= 5'd0;
            sy_prev_q   <= 5'd0;
            win_reuse_q <= 1'b0;
        end else begin
            sx_prev_q   <= sx_prev_d;
            sy_prev_q   <= sy_prev_d;
            win_reuse_q <= win_reuse_d;
        end
    end

    assign WIN_REUSE = win_reuse_q;
`else
    assign reuse_hit = 1'b0;
    assign WIN_REUSE = 1'b0;
`endif

    assign BUSY      = (state_q != IDLE) && (state_q != FINISH);
    assign DONE      = (state_q == FINISH);
    assign ROM_REQ   = (state_q == FETCH);
    assign ROM_A     = (state_q == FETCH)
                     ? ROM_AW'((32'(v0_q) + 32'(row_c)) * 32'(IMG_W) + 32'(h0_q) + 32'(col_c))
                     : '0;
    assign PIX_VALID = pix_valid_q;
    assign WIN_LAST  = win_last_q;
    assign FX_NUM    = fx_rem;
    assign FY_NUM    = fy_rem;
    assign FX_DEN    = fx_den_q;
    assign FY_DEN    = fy_den_q;
    assign SRAM_WEN  = (state_q == WRITE);
    assign SRAM_A    = sram_a_q;
endmodule

// File: tb/tb_bicubic_ctrl.sv
// tb_bicubic_ctrl: scoreboard bench; a reference model queues expected ROM fetches and
// SRAM writes per job, a monitor pops and compares them as the controller produces them.
module tb_bicubic_ctrl;
`ifdef BICUBIC_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif
    localparam int PITCH = 100;

    typedef struct {
        int a;
        int fxn;
        int fyn;
        int fxd;
        int fyd;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        BUSY;
    logic [6:0]  H0, V0;
    logic [4:0]  SW, SH;
    logic [5:0]  TW, TH;
    logic        ROM_REQ;
    logic [13:0] ROM_A;
    logic        PIX_VALID, WIN_LAST;
    logic [5:0]  FX_NUM, FY_NUM, FX_DEN, FY_DEN;
    logic        DP_DONE;
    logic        SRAM_WEN;
    logic [11:0] SRAM_A;
    logic        DONE, WIN_REUSE;

    exp_t rom_q[$];
    exp_t sram_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_req    = 0;
    int   dp_dly   = 3;

    bicubic_ctrl dut (
        .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY),
        .H0(H0), .V0(V0), .SW(SW), .SH(SH), .TW(TW), .TH(TH),
        .ROM_REQ(ROM_REQ), .ROM_A(ROM_A), .PIX_VALID(PIX_VALID), .WIN_LAST(WIN_LAST),
        .FX_NUM(FX_NUM), .FY_NUM(FY_NUM), .FX_DEN(FX_DEN), .FY_DEN(FY_DEN),
        .DP_DONE(DP_DONE), .SRAM_WEN(SRAM_WEN), .SRAM_A(SRAM_A), .DONE(DONE),
        .WIN_REUSE(WIN_REUSE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    function automatic void build_model(input int h0, input int v0, input int sw, input int sh,
                                        input int tw, input int th, output int nreq);
        int   sx, sy, fxn, fyn, fxd, fyd, psx;
        exp_t e;
        nreq = 0;
        psx  = -1;
        for (int ty = 0; ty < th; ty++) begin
            for (int tx = 0; tx < tw; tx++) begin
                if (tw == 1) begin sx = 0; fxn = 0; fxd = 1; end
                else begin sx = tx * (sw - 1) / (tw - 1); fxn = tx * (sw - 1) % (tw - 1); fxd = tw - 1; end
                if (th == 1) begin sy = 0; fyn = 0; fyd = 1; end
                else begin sy = ty * (sh - 1) / (th - 1); fyn = ty * (sh - 1) % (th - 1); fyd = th - 1; end
                if (!(REUSE && tx != 0 && sx == psx)) begin
                    for (int j = 0; j < 4; j++) begin
                        for (int i = 0; i < 4; i++) begin
                            e.a   = (v0 + clampi(sy - 1 + j, sh - 1)) * PITCH + h0 + clampi(sx - 1 + i, sw - 1);
                            e.fxn = fxn; e.fyn = fyn; e.fxd = fxd; e.fyd = fyd;
                            rom_q.push_back(e);
                        end
                    end
                    nreq += 16;
                end
                e.a = ty * tw + tx;
                e.fxn = fxn; e.fyn = fyn; e.fxd = fxd; e.fyd = fyd;
                sram_q.push_back(e);
                psx = sx;
            end
        end
    endfunction

    // Datapath stand-in: answers dp_dly cycles after a window completes (0 = same cycle).
    initial begin
        DP_DONE = 1'b0;
        forever begin
            @(negedge CLK);
            DP_DONE = 1'b0;
            if (WIN_LAST || WIN_REUSE) begin
                repeat (dp_dly) @(negedge CLK);
                DP_DONE = 1'b1;
            end
        end
    end

    initial begin
        exp_t e;
        logic prev_req  = 1'b0;
        logic prev_last = 1'b0;
        int   in_win    = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_req  = 1'b0;
                prev_last = 1'b0;
                in_win    = 0;
            end else begin
                if (prev_req || PIX_VALID) begin
                    check("pix_valid", PIX_VALID, prev_req);
                    check("win_last", WIN_LAST, prev_last);
                end
                prev_last = 1'b0;
                if (ROM_REQ) begin
                    n_req++;
                    in_win++;
                    if (in_win == 16) begin prev_last = 1'b1; in_win = 0; end
                    if (rom_q.size() == 0) check("rom_unexpected", ROM_REQ, 0);
                    else begin
                        e = rom_q.pop_front();
                        check("rom_a", ROM_A, e.a);
                        check("fx_num_fetch", FX_NUM, e.fxn);
                        check("fy_num_fetch", FY_NUM, e.fyn);
                    end
                end
                prev_req = ROM_REQ;
                if (SRAM_WEN) begin
                    if (sram_q.size() == 0) check("sram_unexpected", SRAM_WEN, 0);
                    else begin
                        e = sram_q.pop_front();
                        check("sram_a", SRAM_A, e.a);
                        check("fx_num_wr", FX_NUM, e.fxn);
                        check("fy_num_wr", FY_NUM, e.fyn);
                        check("fx_den_wr", FX_DEN, e.fxd);
                        check("fy_den_wr", FY_DEN, e.fyd);
                    end
                end
            end
        end
    end

    task automatic drive_start(input int h0, input int v0, input int sw, input int sh,
                               input int tw, input int th);
        @(negedge CLK);
        H0 = 7'(h0); V0 = 7'(v0); SW = 5'(sw); SH = 5'(sh); TW = 6'(tw); TH = 6'(th);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic run_job(input int h0, input int v0, input int sw, input int sh,
                           input int tw, input int th, input int dly, input bit poke);
        int exp_req, base_req;
        build_model(h0, v0, sw, sh, tw, th, exp_req);
        dp_dly   = dly;
        base_req = n_req;
        drive_start(h0, v0, sw, sh, tw, th);
        for (int i = 0; i < 20000 && !DONE; i++) begin
            @(negedge CLK);
            START = (poke && i == 40);
        end
        START = 1'b0;
        check("done", DONE, 1);
        check("busy_end", BUSY, 0);
        check("rom_count", n_req - base_req, exp_req);
        check("rom_q_left", rom_q.size(), 0);
        check("sram_q_left", sram_q.size(), 0);
        repeat (3) @(negedge CLK);
        check("done_hold", DONE, 1);
        rom_q.delete();
        sram_q.delete();
    endtask

    initial begin
        int cnt;
        int dummy;
        RST = 1'b1; START = 1'b0;
        H0 = '0; V0 = '0; SW = '0; SH = '0; TW = '0; TH = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_done", DONE, 0);
        check("rst_busy", BUSY, 0);
        check("rst_rom_req", ROM_REQ, 0);
        check("rst_sram_wen", SRAM_WEN, 0);
        check("rst_rom_a", ROM_A, 0);
        check("rst_sram_a", SRAM_A, 0);
        check("rst_fx_den", FX_DEN, 0);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("idle_busy", BUSY, 0);

        run_job(0, 0, 4, 4, 4, 4, 3, 1'b0);
        run_job(0, 0, 5, 3, 9, 2, 0, 1'b1);
        run_job(90, 90, 10, 10, 10, 10, 1, 1'b0);

        // Reset in the 5th fetch cycle, then confirm the block stays idle.
        build_model(0, 0, 4, 4, 4, 4, dummy);
        dp_dly = 3;
        drive_start(0, 0, 4, 4, 4, 4);
        cnt = 0;
        for (int i = 0; i < 200 && cnt < 5; i++) begin
            @(posedge CLK);
            #1;
            if (ROM_REQ) cnt++;
        end
        check("rst_fetch_reached", cnt, 5);
        RST = 1'b1;
        #1;
        check("midrst_rom_req", ROM_REQ, 0);
        check("midrst_rom_a", ROM_A, 0);
        check("midrst_busy", BUSY, 0);
        check("midrst_fx_den", FX_DEN, 0);
        check("midrst_sram_a", SRAM_A, 0);
        rom_q.delete();
        sram_q.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (6) @(negedge CLK);
        check("post_rst_busy", BUSY, 0);
        check("post_rst_rom_req", ROM_REQ, 0);
        run_job(5, 3, 6, 7, 3, 5, 2, 1'b0);

        run_job(0, 0, 5, 5, 9, 9, 0, 1'b0);
        run_job(10, 20, 7, 6, 1, 1, 1, 1'b0);
        run_job(30, 40, 20, 12, 3, 4, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
